mux_arb_n: RTL and testbench

- Parametrised N-input, WIDTH-bit selecting multiplexer with a valid/ready handshake on every channel.
- Output is registered in a single-entry buffer.
- Three selection modes: explicit select (the classic mux behaviour), fixed priority, and round-robin arbitration.
- Sits in the multicycle CPU datapath and memory-side paths wherever several producers share one consumer.

---
 rtl/mux_arb_pkg.sv | 9 +
 rtl/mux_arb_n_rr_grant.sv | 27 ++
 rtl/mux_arb_n.sv | 112 +++++++++++
 tb/tb_mux_arb_n.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared selection-mode encodings for mux_arb_n.
package mux_arb_pkg;

  localparam logic [1:0] MODE_SEL  = 2'd0;
  localparam logic [1:0] MODE_PRIO = 2'd1;
  localparam logic [1:0] MODE_RR   = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

endpackage

// File: rtl/mux_arb_n_rr_grant.sv
// Rotating-priority encoder: first asserted request at or after ptr, wrapping N-1 -> 0.
module rr_grant #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] idx,
  output logic            found
);

  int c;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = SELW'(c);
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-way valid/ready mux with explicit/priority/round-robin select into a 1-entry output register.
// 1-cycle transfer latency; loads only when the register is empty or draining. Optional MUX_ARB_LOCK_EN.
module mux_arb_n
  import mux_arb_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       mode,
`ifdef MUX_ARB_LOCK_EN
  input  logic             i_lock,
`endif
  input  logic [SELW-1:0]  sel,
  input  logic [N-1:0]     i_valid,
  input  logic [N*WIDTH-1:0] i_data,
  output logic [N-1:0]     o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [SELW-1:0]  o_chan,
  input  logic             i_ready
);

  logic            can_load;
  logic            grant_vld;
  logic            xfer;
  logic            lock_act;
  logic [SELW-1:0] grant_idx;
  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] enc_ptr;
  logic [SELW-1:0] enc_idx;
  logic            enc_found;
  logic            sel_hit;

`ifdef MUX_ARB_LOCK_EN
  logic [SELW-1:0] lock_chan;
  logic            lock_hit;

  assign lock_act = i_lock && (mode == MODE_PRIO || mode == MODE_RR);
  assign lock_hit = |(i_valid & (N'(1) << lock_chan));
`else
  assign lock_act = 1'b0;
`endif

  // Fixed priority is the rotating encoder with its pointer pinned to channel 0.
  assign enc_ptr = (mode == MODE_RR) ? rr_ptr : '0;

  rr_grant #(.N(N)) u_rr_grant (
    .req   (i_valid),
    .ptr   (enc_ptr),
    .idx   (enc_idx),
    .found (enc_found)
  );

  // An out-of-range sel shifts the one-hot mask away entirely, so it never hits.
  assign sel_hit = |(i_valid & (N'(1) << sel));

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    case (mode)
      MODE_SEL: begin
        grant_idx = sel;
        grant_vld = sel_hit;
      end
      MODE_PRIO, MODE_RR: begin
        grant_idx = enc_idx;
        grant_vld = enc_found;
      end
      default: ;
    endcase
`ifdef MUX_ARB_LOCK_EN
    if (lock_act) begin
      grant_idx = lock_chan;
      grant_vld = lock_hit;
    end
`endif
  end

  assign can_load = !o_valid || i_ready;
  assign xfer     = grant_vld && can_load;
  assign o_ready  = xfer ? (N'(1) << grant_idx) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_chan  <= '0;
      rr_ptr  <= '0;
    end else if (xfer) begin
      o_valid <= 1'b1;
      o_data  <= i_data[int'(grant_idx)*WIDTH +: WIDTH];
      o_chan  <= grant_idx;
      if (mode == MODE_RR && !lock_act)
        rr_ptr <= (int'(grant_idx) == N-1) ? '0 : SELW'(int'(grant_idx) + 1);
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifdef MUX_ARB_LOCK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      lock_chan <= '0;
    else if (xfer)
      lock_chan <= grant_idx;
  end
`endif

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n (N=4, WIDTH=32); lock scenario only when MUX_ARB_LOCK_EN is defined.
module tb_mux_arb_n;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [1:0]     mode;
  logic           i_lock;
  logic [1:0]     sel;
  logic [N-1:0]   i_valid;
  logic [N*W-1:0] i_data;
  logic [N-1:0]   o_ready;
  logic           o_valid;
  logic [W-1:0]   o_data;
  logic [1:0]     o_chan;
  logic           i_ready;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_arb_n #(.WIDTH(W), .N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mode    (mode),
`ifdef MUX_ARB_LOCK_EN
    .i_lock  (i_lock),
`endif
    .sel     (sel),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_chan  (o_chan),
    .i_ready (i_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] d3);
    i_data = {d3, d2, d1, d0};
  endtask

  logic [W-1:0] chd [N];

  initial begin
    chd[0] = 32'h0F; chd[1] = 32'h11; chd[2] = 32'h22; chd[3] = 32'h33;
    reset_n = 1'b0;
    mode = 2'd0; i_lock = 1'b0; sel = '0; i_valid = '0; i_ready = 1'b0;
    set_data(chd[0], chd[1], chd[2], chd[3]);
    #12;
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_data",  64'(o_data),  64'd0);
    check("rst_o_ready", 64'(o_ready), 64'd0);

    // Load DEADBEEF via RR (advances pointer to 2), then reset mid-cycle.
    @(negedge clk);
    reset_n = 1'b1;
    step();
    mode = 2'd2; i_valid = 4'b0010; i_ready = 1'b0;
    set_data(chd[0], 32'hDEAD_BEEF, chd[2], chd[3]);
    #1;
    check("rr_first_ready", 64'(o_ready), 64'b0010);
    step();
    check("load_o_valid", 64'(o_valid), 64'd1);
    check("load_o_data",  64'(o_data),  64'hDEAD_BEEF);
    i_valid = '0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_o_valid", 64'(o_valid), 64'd0);
    check("async_o_data",  64'(o_data),  64'd0);
    check("async_o_chan",  64'(o_chan),  64'd0);
    #1;
    reset_n = 1'b1;
    set_data(chd[0], chd[1], chd[2], chd[3]);
    mode = 2'd2; i_valid = 4'b1111; i_ready = 1'b1;
    #1;
    check("rr_after_rst", 64'(o_ready), 64'b0001);

    // Full round-robin sweep, one beat per cycle.
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_valid", 64'(o_valid), 64'd1);
      check("rr_chan",  64'(o_chan),  64'(i % N));
      check("rr_data",  64'(o_data),  64'(chd[i % N]));
    end

    // Explicit select.
    mode = 2'd0; sel = 2'd2; i_valid = 4'b1111;
    #1;
    check("sel_ready", 64'(o_ready), 64'b0100);
    step();
    check("sel_valid", 64'(o_valid), 64'd1);
    check("sel_data",  64'(o_data),  64'h22);
    check("sel_chan",  64'(o_chan),  64'd2);
    i_valid = 4'b1011;
    #1;
    check("sel_idle_ready", 64'(o_ready), 64'b0000);
    step();
    check("drain_valid", 64'(o_valid), 64'd0);
    check("drain_data",  64'(o_data),  64'h22);
    check("drain_chan",  64'(o_chan),  64'd2);

    // Fixed priority: ch1 beats ch3 until ch1 drops.
    mode = 2'd1; i_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("prio_ready", 64'(o_ready), 64'b0010);
      step();
      check("prio_chan", 64'(o_chan), 64'd1);
    end
    i_valid = 4'b1000;
    #1;
    check("prio_ch3_ready", 64'(o_ready), 64'b1000);
    step();
    check("prio_ch3_chan", 64'(o_chan), 64'd3);
    check("prio_ch3_data", 64'(o_data), 64'h33);

    // Back-pressure: held beat 5 stalls ch1, then swap in one edge.
    set_data(32'h5, chd[1], chd[2], chd[3]);
    i_valid = 4'b0001;
    step();
    check("bp_load_data", 64'(o_data), 64'h5);
    i_ready = 1'b0; i_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", 64'(o_ready), 64'b0000);
      step();
      check("bp_valid", 64'(o_valid), 64'd1);
      check("bp_data",  64'(o_data),  64'h5);
      check("bp_chan",  64'(o_chan),  64'd0);
    end
    i_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(o_ready), 64'b0010);
    step();
    check("bp_swap_valid", 64'(o_valid), 64'd1);
    check("bp_swap_data",  64'(o_data),  64'h11);
    check("bp_swap_chan",  64'(o_chan),  64'd1);

    // Reserved mode grants nothing but still drains.
    set_data(chd[0], chd[1], chd[2], chd[3]);
    mode = 2'd3; i_valid = 4'b1111;
    #1;
    check("rsvd_ready", 64'(o_ready), 64'b0000);
    step();
    check("rsvd_drain", 64'(o_valid), 64'd0);

    // Sparse round-robin from pointer 0 (last RR grant was ch3): 1,3,1.
    mode = 2'd2; i_valid = 4'b1010;
    step();
    check("rr_sparse0", 64'(o_chan), 64'd1);
    step();
    check("rr_sparse1", 64'(o_chan), 64'd3);
    step();
    check("rr_sparse2", 64'(o_chan), 64'd1);

`ifdef MUX_ARB_LOCK_EN
    // Pointer is 2 here; ch0 wins by wrap and pointer becomes 1.
    i_valid = 4'b0011;
    #1;
    check("lock_first_ready", 64'(o_ready), 64'b0001);
    step();
    check("lock_first_chan", 64'(o_chan), 64'd0);
    i_lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lock_ready", 64'(o_ready), 64'b0001);
      step();
      check("lock_chan", 64'(o_chan), 64'd0);
    end
    i_valid = 4'b0010;
    #1;
    check("lock_idle_ready", 64'(o_ready), 64'b0000);
    i_valid = 4'b0011; i_lock = 1'b0;
    #1;
    check("unlock_ready", 64'(o_ready), 64'b0010);
    step();
    check("unlock_chan", 64'(o_chan), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
